vga_scan_ctrl: RTL and testbench
================================

// Module: vga_scan_ctrl
// PURPOSE
//  Upstream timing generator and downstream output stage for the page renderers.
//  Generates raster coordinates x_pos/y_pos that drive the page pixel stages
//  (e.g. the main-menu page). Takes back their registered 12-bit pixel_data.
//  Delays sync/blank by the page latency so colour and sync line up at the VGA pins.
// PARAMETERS
//  H_VIS    640  visible pixels per line
//  H_FP     16   horizontal front porch (clocks)
//  H_SYNC   96   horizontal sync width (clocks)
//  H_BP     48   horizontal back porch (clocks)
//  V_VIS    480  visible lines per frame
//  V_FP     10   vertical front porch (lines)
//  V_SYNC   2    vertical sync width (lines)
//  V_BP     33   vertical back porch (lines)
//  SYNC_POL 0    sync active level (0 = active-low)
//  PIX_LAT  1    clocks from x_pos/y_pos change to matching pixel_data (range 1..4)
// PORTS
//  vga_clk     in   1   pixel clock, 25 MHz for default timing
//  vga_rst     in   1   asynchronous, active-high reset
//  pixel_data  in   12  page pixel {B[3:0],G[3:0],R[3:0]}, PIX_LAT clocks after coords
//  x_pos       out  10  visible column 0..H_VIS-1, 0 while blanking
//  y_pos       out  10  visible row 0..V_VIS-1, 0 while blanking
//  frame_start out  1   one-clock pulse when h_cnt==0 && v_cnt==0
//  hs          out  1   horizontal sync at pins, aligned with vga_r/g/b
//  vs          out  1   vertical sync at pins, aligned with vga_r/g/b
//  vga_r       out  4   red at pins, 0 while blanking
//  vga_g       out  4   green at pins, 0 while blanking
//  vga_b       out  4   blue at pins, 0 while blanking
// BEHAVIOUR
//  - Counters
//    - h_cnt counts 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800).
//    - When h_cnt wraps to 0, v_cnt increments 0..V_TOT-1, where V_TOT = 525.
//    - v_cnt wraps to 0 after line V_TOT-1.
//    - Order within each line and frame: visible, front porch, sync, back porch.
//  - Active/sync decode (stage 0)
//    - de0 = h_cnt<H_VIS && v_cnt<V_VIS.
//    - hs0 is active while h_cnt is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC).
//    - vs0 is active while v_cnt is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC).
//    - Active level = SYNC_POL.
//  - Coordinates
//    - x_pos/y_pos are registered from h_cnt/v_cnt in the same cycle as de0.
//    - Both are forced to 0 when de0=0, so the page address never exceeds H_VIS*V_VIS-1.
//    - Width: zero-extended to 10 bits.
//  - Delay line
//    - de/hs/vs pass through a PIX_LAT-deep shift register, so they pair with pixel_data.
//  - Output register (one more clock)
//    - vga_b = de_d ? pixel_data[11:8] : 0
//    - vga_g = de_d ? pixel_data[7:4] : 0
//    - vga_r = de_d ? pixel_data[3:0] : 0
//    - hs = hs_d, vs = vs_d.
//    - Total coordinate-to-pin latency = PIX_LAT+1 clocks; syncs carry the same latency.
//  - frame_start is a registered pulse aligned with x_pos=0,y_pos=0 of a new frame.
//  - Reset (async, takes effect immediately; also applies mid-frame)
//    - h_cnt, v_cnt, x_pos, y_pos, frame_start, vga_r/g/b = 0.
//    - hs, vs and all delay-line syncs = inactive (~SYNC_POL).
//    - All delay-line de = 0.
//  - Release from reset
//    - First clock: h_cnt=0, v_cnt=0, frame_start=1.
//    - Scan restarts at pixel (0,0); no partial-frame garbage appears at the pins.
//  - Simultaneous wraps: at h_cnt=H_TOT-1 && v_cnt=V_TOT-1, both counters wrap to 0 on the same edge.
//  - pixel_data is ignored whenever de_d=0.
// TESTING
//  - Reset, then run 1 line -> hs period 800 clks, active-low for 96 clks, first falling edge at clk 656+PIX_LAT+1.
//  - Run 1 frame -> vs period 420000 clks, low for 1600 clks (2 lines), frame_start pulses exactly once per frame.
//  - Page model: pixel_data = {x_pos[3:0],y_pos[3:0],4'hA}, delayed PIX_LAT -> pin pixel (5,3) gives b=5,g=3,r=A at the correct clock.
//  - Blanking: pixel_data forced to 12'hFFF -> vga_r/g/b=0 for all of h_cnt>=640 and v_cnt>=480; x_pos=y_pos=0 there.
//  - Reset asserted at (x=300,y=200) for 3 clks -> outputs at reset values immediately; after release, frame_start=1 and x_pos counts 0,1,2...
//  - Boundary: last visible pixel (639,479) reaches the pins, then the next clock is blank; x_pos max=639 and y_pos max=479 over a full frame.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// VGA raster timing generator and pin output stage for the page renderers.
// Coordinates go out to the page pipeline; sync/blank are delayed to meet its pixel_data.
module vga_scan_ctrl #(
    parameter int   H_VIS    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_VIS    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIX_LAT  = 1
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic [11:0] pixel_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W = 10'(V_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       de0;
    logic       hs0;
    logic       vs0;

    // Bit 0 is registered alongside x_pos/y_pos; bit PIX_LAT lines up with pixel_data.
    logic [PIX_LAT:0] de_sr;
    logic [PIX_LAT:0] hs_sr;
    logic [PIX_LAT:0] vs_sr;

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 10'd1;
            end
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_comb begin
        de0 = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);
        hs0 = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs0 = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Coordinates are zeroed in blanking so the page address stays inside the visible area.
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
            de_sr       <= '0;
            hs_sr       <= {(PIX_LAT + 1){~SYNC_POL}};
            vs_sr       <= {(PIX_LAT + 1){~SYNC_POL}};
        end else begin
            x_pos       <= de0 ? h_cnt : 10'd0;
            y_pos       <= de0 ? v_cnt : 10'd0;
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            de_sr       <= {de_sr[PIX_LAT-1:0], de0};
            hs_sr       <= {hs_sr[PIX_LAT-1:0], hs0};
            vs_sr       <= {vs_sr[PIX_LAT-1:0], vs0};
        end
    end

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            vga_r <= 4'h0;
            vga_g <= 4'h0;
            vga_b <= 4'h0;
            hs    <= ~SYNC_POL;
            vs    <= ~SYNC_POL;
        end else begin
            vga_b <= de_sr[PIX_LAT] ? pixel_data[11:8] : 4'h0;
            vga_g <= de_sr[PIX_LAT] ? pixel_data[7:4]  : 4'h0;
            vga_r <= de_sr[PIX_LAT] ? pixel_data[3:0]  : 4'h0;
            hs    <= hs_sr[PIX_LAT];
            vs    <= vs_sr[PIX_LAT];
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a shrunken-timing instance checked over whole frames and a
// default-timing instance checked over its first lines, both against an arithmetic raster model.
module tb_vga_scan_ctrl;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int lat;
    } tim_t;

    localparam int S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 8,  S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_LAT = 2;
    localparam int D_LAT = 1;
    localparam tim_t S_TIM = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_LAT};
    localparam tim_t D_TIM = '{640, 16, 96, 48, 480, 10, 2, 33, D_LAT};
    localparam logic [34:0] RST_PACK = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000};

    logic        vga_clk;
    logic        vga_rst;
    logic        fff;
    int          checks = 0;
    int          errors = 0;
    int          rel_edges = 0;

    logic [11:0] s_pix = 12'h000;
    logic [9:0]  s_x, s_y;
    logic        s_fs, s_hs, s_vs;
    logic [3:0]  s_r, s_g, s_b;
    logic [11:0] d_pix = 12'h000;
    logic [9:0]  d_x, d_y;
    logic        d_fs, d_hs, d_vs;
    logic [3:0]  d_r, d_g, d_b;

    wire logic [34:0] s_pack = {s_x, s_y, s_fs, s_hs, s_vs, s_b, s_g, s_r};
    wire logic [34:0] d_pack = {d_x, d_y, d_fs, d_hs, d_vs, d_b, d_g, d_r};

    vga_scan_ctrl #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b0), .PIX_LAT(S_LAT)
    ) dut_small (
        .vga_clk(vga_clk), .vga_rst(vga_rst), .pixel_data(s_pix),
        .x_pos(s_x), .y_pos(s_y), .frame_start(s_fs), .hs(s_hs), .vs(s_vs),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    vga_scan_ctrl dut_default (
        .vga_clk(vga_clk), .vga_rst(vga_rst), .pixel_data(d_pix),
        .x_pos(d_x), .y_pos(d_y), .frame_start(d_fs), .hs(d_hs), .vs(d_vs),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // t counts clocks from the frame_start cycle after release; pins show coordinate t-(lat+1).
    function automatic logic [34:0] model(input tim_t c, input int t, input bit all_white);
        int htot, vtot, frame, p, hc, vc, q;
        logic [9:0] x, y;
        logic fs, hsx, vsx;
        logic [3:0] r, g, b;
        htot = c.hv + c.hf + c.hs + c.hb;
        vtot = c.vv + c.vf + c.vs + c.vb;
        frame = htot * vtot;
        p = t % frame;
        hc = p % htot;
        vc = p / htot;
        x = (hc < c.hv && vc < c.vv) ? 10'(hc) : 10'd0;
        y = (hc < c.hv && vc < c.vv) ? 10'(vc) : 10'd0;
        fs = (p == 0);
        hsx = 1'b1;
        vsx = 1'b1;
        r = 4'h0;
        g = 4'h0;
        b = 4'h0;
        q = t - (c.lat + 1);
        if (q >= 0) begin
            p = q % frame;
            hc = p % htot;
            vc = p / htot;
            hsx = !(hc >= c.hv + c.hf && hc < c.hv + c.hf + c.hs);
            vsx = !(vc >= c.vv + c.vf && vc < c.vv + c.vf + c.vs);
            if (hc < c.hv && vc < c.vv) begin
                if (all_white) begin
                    {b, g, r} = 12'hFFF;
                end else begin
                    b = 4'(hc);
                    g = 4'(vc);
                    r = 4'hA;
                end
            end
        end
        return {x, y, fs, hsx, vsx, b, g, r};
    endfunction

    task automatic checkOutput(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Page emulation: pixel_data during cycle n is built from the coordinates of cycle n-lat.
    initial begin
        logic [9:0] hx [0:S_LAT];
        logic [9:0] hy [0:S_LAT];
        for (int i = 0; i <= S_LAT; i++) begin
            hx[i] = '0;
            hy[i] = '0;
        end
        forever begin
            @(negedge vga_clk);
            for (int i = S_LAT; i > 0; i--) begin
                hx[i] = hx[i-1];
                hy[i] = hy[i-1];
            end
            hx[0] = s_x;
            hy[0] = s_y;
            s_pix = fff ? 12'hFFF : {hx[S_LAT][3:0], hy[S_LAT][3:0], 4'hA};
        end
    end

    initial begin
        logic [9:0] hx [0:D_LAT];
        logic [9:0] hy [0:D_LAT];
        for (int i = 0; i <= D_LAT; i++) begin
            hx[i] = '0;
            hy[i] = '0;
        end
        forever begin
            @(negedge vga_clk);
            for (int i = D_LAT; i > 0; i--) begin
                hx[i] = hx[i-1];
                hy[i] = hy[i-1];
            end
            hx[0] = d_x;
            hy[0] = d_y;
            d_pix = fff ? 12'hFFF : {hx[D_LAT][3:0], hy[D_LAT][3:0], 4'hA};
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        int edges;
        edges = 0;
        forever begin
            @(negedge vga_clk);
            if (vga_rst) begin
                edges = 0;
                checkOutput("small_reset", s_pack, RST_PACK);
                checkOutput("default_reset", d_pack, RST_PACK);
            end else begin
                edges++;
                checkOutput($sformatf("small_scan t=%0d", edges - 1), s_pack,
                            model(S_TIM, edges - 1, fff));
                checkOutput($sformatf("default_scan t=%0d", edges - 1), d_pack,
                            model(D_TIM, edges - 1, fff));
            end
        end
    end

    task automatic stepTo(input int t);
        if (rel_edges < t + 1) begin
            while (rel_edges < t + 1) begin
                @(posedge vga_clk);
                rel_edges++;
            end
            #2;
        end
    endtask

    task automatic applyStimulus(input int hold_clocks, input bit white);
        vga_rst = 1'b1;
        fff = white;
        repeat (hold_clocks) @(posedge vga_clk);
        @(negedge vga_clk);
        #1;
        vga_rst = 1'b0;
        rel_edges = 0;
    endtask

    initial begin
        vga_rst = 1'b0;
        fff = 1'b0;
        #1;
        applyStimulus(3, 1'b0);

        stepTo(0);
        checkOutput("fs_first_clock", 35'(s_fs), 35'd1);
        checkOutput("x_first_clock", 35'(s_x), 35'd0);
        stepTo(1);
        checkOutput("x_second_clock", 35'(s_x), 35'd1);
        checkOutput("fs_single_pulse", 35'(s_fs), 35'd0);
        stepTo(20);
        checkOutput("hs_before_fall", 35'(s_hs), 35'd1);
        stepTo(21);
        checkOutput("hs_first_fall", 35'(s_hs), 35'd0);
        stepTo(23);
        checkOutput("hs_last_low", 35'(s_hs), 35'd0);
        stepTo(24);
        checkOutput("hs_rise", 35'(s_hs), 35'd1);
        stepTo(80);
        checkOutput("pixel_5_3", 35'({s_b, s_g, s_r}), 35'(12'h53A));
        stepTo(186);
        checkOutput("last_visible_pixel", 35'({s_b, s_g, s_r}), 35'(12'hF7A));
        stepTo(187);
        checkOutput("after_last_visible", 35'({s_b, s_g, s_r}), 35'd0);
        stepTo(218);
        checkOutput("vs_before_fall", 35'(s_vs), 35'd1);
        stepTo(219);
        checkOutput("vs_fall", 35'(s_vs), 35'd0);
        stepTo(266);
        checkOutput("vs_last_low", 35'(s_vs), 35'd0);
        stepTo(267);
        checkOutput("vs_rise", 35'(s_vs), 35'd1);
        stepTo(312);
        checkOutput("fs_next_frame", 35'({s_fs, s_x, s_y}), 35'({1'b1, 20'd0}));
        stepTo(639);
        checkOutput("default_x_max", 35'(d_x), 35'd639);
        stepTo(640);
        checkOutput("default_x_blank", 35'(d_x), 35'd0);
        stepTo(657);
        checkOutput("default_hs_before_fall", 35'(d_hs), 35'd1);
        stepTo(658);
        checkOutput("default_hs_fall", 35'(d_hs), 35'd0);
        stepTo(2407);
        checkOutput("default_pixel_5_3", 35'({d_b, d_g, d_r}), 35'(12'h53A));

        stepTo(2626);
        checkOutput("pre_reset_x", 35'(s_x), 35'd10);
        checkOutput("pre_reset_y", 35'(s_y), 35'd5);
        vga_rst = 1'b1;
        #1;
        checkOutput("small_reset_immediate", s_pack, RST_PACK);
        checkOutput("default_reset_immediate", d_pack, RST_PACK);
        applyStimulus(3, 1'b0);
        stepTo(0);
        checkOutput("fs_after_reset", 35'({s_fs, s_x}), 35'({1'b1, 10'd0}));
        stepTo(1);
        checkOutput("x_after_reset_1", 35'(s_x), 35'd1);
        stepTo(2);
        checkOutput("x_after_reset_2", 35'(s_x), 35'd2);
        stepTo(30);

        applyStimulus(2, 1'b1);
        stepTo(19);
        checkOutput("white_blank_column", 35'({s_b, s_g, s_r}), 35'd0);
        stepTo(80);
        checkOutput("white_visible", 35'({s_b, s_g, s_r}), 35'(12'hFFF));
        stepTo(187);
        checkOutput("white_after_last_visible", 35'({s_b, s_g, s_r}), 35'd0);
        stepTo(330);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
